// File: rtl/rom_loader_128x8_pkg.sv
// Shared definitions for the program-memory loader and the memory wrappers:
// default memory geometry and the loader state encoding.
package rom_loader_128x8_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

endpackage

// File: rtl/rom_loader_128x8_sum.sv
// Clearable modular accumulator; total shows the value including this cycle's
// addend so a result can be compared in the same cycle as the final add.
module sum8_acc
  import rom_loader_128x8_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] addend,
  output logic [WIDTH-1:0] total
);

  logic [WIDTH-1:0] acc;

  always_comb begin
    total = acc;
    if (clear) begin
      total = '0;
    end else if (enable) begin
      total = acc + addend;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else begin
      acc <= total;
    end
  end

endmodule

// File: rtl/rom_loader_128x8.sv
// Program-memory loader: streams bytes into port 0, reads them back and checks
// the modular checksum. Port 0 is only meaningful while busy is high.
module rom_loader_128x8
  import rom_loader_128x8_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [MEM_ADDR_WIDTH:0]   load_len,
  input  logic [MEM_DATA_WIDTH-1:0] exp_sum,
  input  logic                      s_valid,
  input  logic [MEM_DATA_WIDTH-1:0] s_data,
  output logic                      s_ready,
  output logic [MEM_ADDR_WIDTH-1:0] address0,
  output logic [MEM_DATA_WIDTH-1:0] data_in0,
  output logic                      rnw0,
  input  logic [MEM_DATA_WIDTH-1:0] data_out0,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [MEM_ADDR_WIDTH:0]   count
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int DW = MEM_DATA_WIDTH;
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  state_t        state;
  state_t        next_state;
  logic [AW:0]   len_q;
  logic [AW:0]   len_sat;
  logic [AW:0]   rd_idx;
  logic [DW-1:0] exp_q;
  logic          start_ok;
  logic          abort_ok;
  logic          handshake;
  logic          last_write;
  logic          last_read;
  logic          rd_pending;
  logic          rd_valid;
  logic [DW-1:0] wr_total;
  logic [DW-1:0] rd_total;

  assign len_sat    = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign start_ok   = (state == ST_IDLE) && start;
  assign abort_ok   = (state inside {ST_LOAD, ST_VERIFY, ST_DRAIN}) && abort;
  assign busy       = (state != ST_IDLE);
  // Gating with abort keeps a byte presented alongside abort unconsumed.
  assign s_ready    = (state == ST_LOAD) && (count < len_q) && !abort;
  assign handshake  = s_valid && s_ready;
  assign last_write = handshake && ((count + ONE) == len_q);
  assign last_read  = ((rd_idx + ONE) == len_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          next_state = (len_sat == '0) ? ST_CHECK : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort_ok) begin
          next_state = ST_IDLE;
        end else if (last_write) begin
          next_state = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (abort_ok) begin
          next_state = ST_IDLE;
        end else if (last_read) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        next_state = abort_ok ? ST_IDLE : ST_CHECK;
      end
      ST_CHECK: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Read data returns one cycle after its address, so rd_valid lags rd_pending.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q      <= '0;
      exp_q      <= '0;
      count      <= '0;
      rd_idx     <= '0;
      address0   <= '0;
      data_in0   <= '0;
      rnw0       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      rd_pending <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      done       <= 1'b0;
      rnw0       <= 1'b1;
      rd_pending <= 1'b0;
      rd_valid   <= rd_pending && !abort_ok;
      if (start_ok) begin
        len_q  <= len_sat;
        exp_q  <= exp_sum;
        count  <= '0;
        rd_idx <= '0;
        pass   <= 1'b0;
      end
      if (abort_ok) begin
        done <= 1'b1;
        pass <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (handshake) begin
              address0 <= count[AW-1:0];
              data_in0 <= s_data;
              rnw0     <= 1'b0;
              count    <= count + ONE;
            end
          end
          ST_VERIFY: begin
            address0   <= rd_idx[AW-1:0];
            rd_idx     <= rd_idx + ONE;
            rd_pending <= 1'b1;
          end
          ST_CHECK: begin
            done <= 1'b1;
            pass <= (rd_total == exp_q) && (rd_total == wr_total);
          end
          default: begin
          end
        endcase
      end
    end
  end

  sum8_acc #(.WIDTH(DW)) u_wr_sum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start_ok),
    .enable  (handshake),
    .addend  (s_data),
    .total   (wr_total)
  );

  sum8_acc #(.WIDTH(DW)) u_rd_sum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start_ok),
    .enable  (rd_valid),
    .addend  (data_out0),
    .total   (rd_total)
  );

endmodule
